// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and the latched SPI mode.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        GAP
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with extra-bit pointers, exact count/full/empty and a registered pop port.
module spi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Handshake: a push is taken only when !full and a pop only when !empty, both judged
    // on registered state; an accepted pop shows up on rd_data with rd_valid one cycle later.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_data <= head;
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI master, modes 0-3, programmable SCLK divider, multiple chip selects,
// fed by a TX FIFO and draining into an RX FIFO with sticky overflow.
module spi_master_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 1
) (
    input  logic                                        clk,
    input  logic                                        srst,
    input  logic [WIDTH-1:0]                            tx_data,
    input  logic                                        tx_wr_en,
    output logic                                        tx_full,
    output logic [$clog2(DEPTH):0]                      tx_count,
    input  logic                                        rx_rd_en,
    output logic [WIDTH-1:0]                            rx_data,
    output logic                                        rx_valid,
    output logic                                        rx_empty,
    output logic [$clog2(DEPTH):0]                      rx_count,
    output logic                                        rx_overflow,
    input  logic                                        cpol,
    input  logic                                        cpha,
    input  logic [DIV_W-1:0]                            clk_div,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
    output logic                                        busy,
    output logic                                        sclk,
    output logic                                        mosi,
    input  logic                                        miso,
    output logic [NUM_CS-1:0]                           cs_n,
    output state_t                                      fsm_state
);

    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EW  = $clog2(2 * WIDTH);

    state_t            state;
    state_t            state_nxt;
    mode_t             mode;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_lat;
    logic [EW-1:0]     edge_cnt;
    logic [WIDTH-1:0]  tx_sh;
    logic [WIDTH-1:0]  rx_sh;
    logic [WIDTH-1:0]  tx_head;
    logic [WIDTH-1:0]  rx_word;
    logic [NUM_CS-1:0] cs_dec;
    logic              tx_empty;
    logic              rx_full;
    logic              tick;
    logic              start;
    logic              toggle;
    logic              odd_edge;
    logic              last_edge;
    logic              sample;
    logic              shift;
    logic              push;
    logic [WIDTH-1:0]  tx_rd_unused;
    logic              tx_valid_unused;
    logic [WIDTH-1:0]  rx_head_unused;

    spi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk      (clk),
        .srst     (srst),
        .wr_en    (tx_wr_en),
        .wr_data  (tx_data),
        .rd_en    (start),
        .head     (tx_head),
        .rd_data  (tx_rd_unused),
        .rd_valid (tx_valid_unused),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    spi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk      (clk),
        .srst     (srst),
        .wr_en    (push),
        .wr_data  (rx_word),
        .rd_en    (rx_rd_en),
        .head     (rx_head_unused),
        .rd_data  (rx_data),
        .rd_valid (rx_valid),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    assign fsm_state = state;
    assign busy      = (state != IDLE);
    assign tick      = (div_cnt == div_lat);

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!tx_empty)         state_nxt = LEAD;
            LEAD:    if (tick)              state_nxt = XFER;
            XFER:    if (tick && last_edge) state_nxt = TRAIL;
            TRAIL:   if (tick)              state_nxt = GAP;
            GAP:     if (tick)              state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Toggle k (1-based) is odd when edge_cnt is even; odd toggles are leading SCLK edges.
    always_comb begin
        start     = (state == IDLE) && !tx_empty;
        toggle    = (state == XFER) && tick;
        odd_edge  = ~edge_cnt[0];
        last_edge = (edge_cnt == EW'(2 * WIDTH - 1));
        sample    = toggle && (mode.cpha ? !odd_edge : odd_edge);
        shift     = toggle && (mode.cpha ? odd_edge : (!odd_edge && !last_edge));
        push      = toggle && last_edge;
        rx_word   = mode.cpha ? {rx_sh[WIDTH-2:0], miso} : rx_sh;
        cs_dec    = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CSW'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            div_cnt     <= '0;
            div_lat     <= '0;
            mode        <= '0;
            edge_cnt    <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            cs_n        <= '1;
            rx_overflow <= 1'b0;
        end else begin
            div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;

            if (state == IDLE) begin
                sclk <= cpol;
            end else if (toggle) begin
                sclk <= ~sclk;
            end else if (state == TRAIL || state == GAP) begin
                sclk <= mode.cpol;
            end

            if (start) begin
                mode.cpol <= cpol;
                mode.cpha <= cpha;
                div_lat   <= clk_div;
                edge_cnt  <= '0;
                cs_n      <= cs_dec;
                if (cpha) begin
                    tx_sh <= tx_head;
                end else begin
                    mosi  <= tx_head[WIDTH-1];
                    tx_sh <= tx_head << 1;
                end
            end

            if (shift) begin
                mosi  <= tx_sh[WIDTH-1];
                tx_sh <= tx_sh << 1;
            end
            if (toggle) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (sample) begin
                rx_sh <= {rx_sh[WIDTH-2:0], miso};
            end
            if (state == TRAIL && tick) begin
                cs_n <= '1;
            end
            if (push && rx_full) begin
                rx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed self-checking bench for spi_master_fifo: modes, framing, FIFO limits, reset, config latching.
module tb_spi_master_fifo;
    import spi_pkg::*;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int DIV_W  = 8;
    localparam int NUM_CS = 2;

    logic             clk;
    logic             srst;
    logic [WIDTH-1:0] tx_data;
    logic             tx_wr_en;
    logic             tx_full;
    logic [4:0]       tx_count;
    logic             rx_rd_en;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_empty;
    logic [4:0]       rx_count;
    logic             rx_overflow;
    logic             cpol;
    logic             cpha;
    logic [DIV_W-1:0] clk_div;
    logic [0:0]       cs_sel;
    logic             busy;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic [1:0]       cs_n;
    state_t           fsm_state;

    logic             loop;
    logic             slave_miso;
    logic [7:0]       slave_tx;
    logic [7:0]       cap;
    int               cap_n;
    logic [7:0]       cap_q[$];
    int               tests_run;
    int               tests_failed;

    spi_master_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W), .NUM_CS(NUM_CS)
    ) dut (
        .clk(clk), .srst(srst), .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full),
        .tx_count(tx_count), .rx_rd_en(rx_rd_en), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_empty(rx_empty), .rx_count(rx_count), .rx_overflow(rx_overflow), .cpol(cpol),
        .cpha(cpha), .clk_div(clk_div), .cs_sel(cs_sel), .busy(busy), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n), .fsm_state(fsm_state)
    );

    assign miso = loop ? mosi : slave_miso;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave-side view: capture mosi on every rising SCLK inside a frame.
    always @(posedge sclk) begin
        if (cs_n != 2'b11) begin
            cap = {cap[6:0], mosi};
            cap_n++;
            if (cap_n % 8 == 0) cap_q.push_back(cap);
        end
    end

    // Mode-3 slave: present the next bit on every falling (leading) SCLK edge.
    always @(negedge sclk) begin
        if (!loop && cs_n != 2'b11) begin
            slave_miso = slave_tx[7];
            slave_tx   = {slave_tx[6:0], 1'b0};
        end
    end

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        tests_run += 11;
        if (tx_full !== 1'b0)     begin tests_failed++; $display("FAIL rst_tx_full: got %b expected 0", tx_full); end
        if (tx_count !== 5'd0)    begin tests_failed++; $display("FAIL rst_tx_count: got %0d expected 0", tx_count); end
        if (rx_data !== 8'h00)    begin tests_failed++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
        if (rx_valid !== 1'b0)    begin tests_failed++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
        if (rx_empty !== 1'b1)    begin tests_failed++; $display("FAIL rst_rx_empty: got %b expected 1", rx_empty); end
        if (rx_count !== 5'd0)    begin tests_failed++; $display("FAIL rst_rx_count: got %0d expected 0", rx_count); end
        if (rx_overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_rx_overflow: got %b expected 0", rx_overflow); end
        if (busy !== 1'b0)        begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (sclk !== 1'b0)        begin tests_failed++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
        if (mosi !== 1'b0)        begin tests_failed++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
        if (cs_n !== 2'b11)       begin tests_failed++; $display("FAIL rst_cs_n: got %b expected 11", cs_n); end
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
        tests_run++;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_empty_read: rx_valid got %b expected 0", rx_valid); end
    endtask

    task automatic test_mode0_loopback();
        int n;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; cs_sel = 1'b0; loop = 1'b1;
        cap_n = 0; cap_q.delete();
        @(negedge clk);
        tx_data = 8'hA5; tx_wr_en = 1'b1;
        @(negedge clk);
        tx_wr_en = 1'b0;
        n = 0;
        while (cs_n == 2'b11 && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (cs_n !== 2'b10) begin tests_failed++; $display("FAIL m0_cs_assert: got %b expected 10", cs_n); end
        n = 0;
        while (cs_n == 2'b10 && n < 200) begin n++; @(negedge clk); end
        tests_run += 2;
        if (n != 36)       begin tests_failed++; $display("FAIL m0_cs_len: got %0d expected 36", n); end
        if (sclk !== 1'b0) begin tests_failed++; $display("FAIL m0_sclk_idle: got %b expected 0", sclk); end
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        tests_run += 4;
        if (busy !== 1'b0)     begin tests_failed++; $display("FAIL m0_busy_end: got %b expected 0", busy); end
        if (rx_count !== 5'd1) begin tests_failed++; $display("FAIL m0_rx_count: got %0d expected 1", rx_count); end
        if (cap_n != 8)        begin tests_failed++; $display("FAIL m0_cap_edges: got %0d expected 8", cap_n); end
        if (cap !== 8'hA5)     begin tests_failed++; $display("FAIL m0_cap_mosi: got %h expected a5", cap); end
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
        tests_run++;
        if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin
            tests_failed++; $display("FAIL m0_rx_read: got valid=%b data=%h expected valid=1 data=a5", rx_valid, rx_data);
        end
        @(negedge clk);
        tests_run += 2;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL m0_rx_pulse: got %b expected 0", rx_valid); end
        if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL m0_rx_empty: got %b expected 1", rx_empty); end
    endtask

    task automatic test_mode3_slave();
        int n;
        cpol = 1'b1; cpha = 1'b1; clk_div = 8'd0; cs_sel = 1'b0; loop = 1'b0;
        slave_tx = 8'h3C; slave_miso = 1'b0;
        cap_n = 0; cap_q.delete();
        repeat (2) @(negedge clk);
        tests_run++;
        if (sclk !== 1'b1) begin tests_failed++; $display("FAIL m3_sclk_idle_pre: got %b expected 1", sclk); end
        tx_data = 8'hC3; tx_wr_en = 1'b1;
        @(negedge clk);
        tx_wr_en = 1'b0;
        n = 0;
        while (cs_n == 2'b11 && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (cs_n !== 2'b10) begin tests_failed++; $display("FAIL m3_cs_assert: got %b expected 10", cs_n); end
        n = 0;
        while (cs_n == 2'b10 && n < 200) begin n++; @(negedge clk); end
        tests_run += 2;
        if (n != 18)       begin tests_failed++; $display("FAIL m3_cs_len: got %0d expected 18", n); end
        if (sclk !== 1'b1) begin tests_failed++; $display("FAIL m3_sclk_idle_post: got %b expected 1", sclk); end
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        tests_run += 2;
        if (cap_n != 8)    begin tests_failed++; $display("FAIL m3_cap_edges: got %0d expected 8", cap_n); end
        if (cap !== 8'hC3) begin tests_failed++; $display("FAIL m3_slave_rx: got %h expected c3", cap); end
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
        tests_run++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin
            tests_failed++; $display("FAIL m3_rx_read: got valid=%b data=%h expected valid=1 data=3c", rx_valid, rx_data);
        end
    endtask

    task automatic test_full_overflow();
        int n;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; cs_sel = 1'b0; loop = 1'b1;
        @(negedge clk);
        cap_n = 0; cap_q.delete();
        for (int i = 0; i < 18; i++) begin
            tx_data = 8'(i); tx_wr_en = 1'b1;
            @(negedge clk);
        end
        tx_wr_en = 1'b0;
        tests_run += 2;
        if (tx_full !== 1'b1)   begin tests_failed++; $display("FAIL ovf_tx_full: got %b expected 1", tx_full); end
        if (tx_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_tx_count: got %0d expected 16", tx_count); end
        n = 0;
        while ((busy || tx_count != 0) && n < 2000) begin @(negedge clk); n++; end
        tests_run++;
        if (n >= 2000) begin tests_failed++; $display("FAIL ovf_drain_timeout: got %0d cycles expected < 2000", n); end
        tests_run += 2;
        if (tx_count !== 5'd0)  begin tests_failed++; $display("FAIL ovf_tx_drained: got %0d expected 0", tx_count); end
        if (cap_q.size() != 17) begin tests_failed++; $display("FAIL ovf_frames: got %0d expected 17", cap_q.size()); end
        for (int i = 0; i < cap_q.size(); i++) begin
            tests_run++;
            if (cap_q[i] !== 8'(i)) begin tests_failed++; $display("FAIL ovf_frame_data[%0d]: got %h expected %h", i, cap_q[i], 8'(i)); end
        end
        tests_run += 3;
        if (rx_count !== 5'd16)   begin tests_failed++; $display("FAIL ovf_rx_count: got %0d expected 16", rx_count); end
        if (rx_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", rx_overflow); end
        if (rx_empty !== 1'b0)    begin tests_failed++; $display("FAIL ovf_rx_not_empty: got %b expected 0", rx_empty); end
        for (int i = 0; i < 16; i++) begin
            rx_rd_en = 1'b1;
            @(negedge clk);
            tests_run++;
            if ({rx_valid, rx_data} !== {1'b1, 8'(i)}) begin
                tests_failed++; $display("FAIL ovf_rx_read[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, rx_valid, rx_data, 8'(i));
            end
        end
        rx_rd_en = 1'b0;
        tests_run += 2;
        if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL ovf_rx_empty: got %b expected 1", rx_empty); end
        if (rx_count !== 5'd0) begin tests_failed++; $display("FAIL ovf_rx_count_end: got %0d expected 0", rx_count); end
    endtask

    task automatic test_config_latch();
        int n;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; cs_sel = 1'b0; loop = 1'b1;
        @(negedge clk);
        tx_data = 8'h5A; tx_wr_en = 1'b1;
        @(negedge clk);
        tx_data = 8'h81;
        @(negedge clk);
        tx_wr_en = 1'b0;
        n = 0;
        while (cs_n == 2'b11 && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (cs_n !== 2'b10) begin tests_failed++; $display("FAIL cfg_cs0_assert: got %b expected 10", cs_n); end
        n = 0;
        while (cs_n == 2'b10 && n < 200) begin
            n++;
            if (n == 5) begin cpol = 1'b1; clk_div = 8'd0; cs_sel = 1'b1; end
            @(negedge clk);
        end
        tests_run++;
        if (n != 36) begin tests_failed++; $display("FAIL cfg_frame1_len: got %0d expected 36", n); end
        n = 0;
        while (cs_n == 2'b11 && n < 50) begin @(negedge clk); n++; end
        tests_run += 2;
        if (cs_n !== 2'b01) begin tests_failed++; $display("FAIL cfg_cs1_assert: got %b expected 01", cs_n); end
        if (sclk !== 1'b1)  begin tests_failed++; $display("FAIL cfg_frame2_cpol: got %b expected 1", sclk); end
        n = 0;
        while (cs_n == 2'b01 && n < 200) begin n++; @(negedge clk); end
        tests_run++;
        if (n != 18) begin tests_failed++; $display("FAIL cfg_frame2_len: got %0d expected 18", n); end
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        tests_run += 2;
        if (sclk !== 1'b1)        begin tests_failed++; $display("FAIL cfg_sclk_idle: got %b expected 1", sclk); end
        if (rx_overflow !== 1'b1) begin tests_failed++; $display("FAIL cfg_ovf_sticky: got %b expected 1", rx_overflow); end
        rx_rd_en = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin
            tests_failed++; $display("FAIL cfg_rx_word1: got valid=%b data=%h expected valid=1 data=5a", rx_valid, rx_data);
        end
        @(negedge clk);
        rx_rd_en = 1'b0;
        tests_run++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h81}) begin
            tests_failed++; $display("FAIL cfg_rx_word2: got valid=%b data=%h expected valid=1 data=81", rx_valid, rx_data);
        end
    endtask

    task automatic test_srst_mid();
        int n;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd3; cs_sel = 1'b0; loop = 1'b1;
        @(negedge clk);
        tx_data = 8'h11; tx_wr_en = 1'b1;
        @(negedge clk);
        tx_data = 8'h22;
        @(negedge clk);
        tx_wr_en = 1'b0;
        n = 0;
        while (fsm_state != XFER && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx_count !== 5'd1) begin tests_failed++; $display("FAIL srst_pre_count: got %0d expected 1", tx_count); end
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        tests_run += 7;
        if (cs_n !== 2'b11)       begin tests_failed++; $display("FAIL srst_cs_n: got %b expected 11", cs_n); end
        if (busy !== 1'b0)        begin tests_failed++; $display("FAIL srst_busy: got %b expected 0", busy); end
        if (tx_count !== 5'd0)    begin tests_failed++; $display("FAIL srst_tx_count: got %0d expected 0", tx_count); end
        if (rx_count !== 5'd0)    begin tests_failed++; $display("FAIL srst_rx_count: got %0d expected 0", rx_count); end
        if (rx_overflow !== 1'b0) begin tests_failed++; $display("FAIL srst_ovf_clear: got %b expected 0", rx_overflow); end
        if (fsm_state !== IDLE)   begin tests_failed++; $display("FAIL srst_state: got %0d expected %0d", fsm_state, IDLE); end
        if (sclk !== 1'b0)        begin tests_failed++; $display("FAIL srst_sclk: got %b expected 0", sclk); end
        repeat (60) @(negedge clk);
        tests_run += 3;
        if (rx_count !== 5'd0) begin tests_failed++; $display("FAIL srst_no_push: got %0d expected 0", rx_count); end
        if (busy !== 1'b0)     begin tests_failed++; $display("FAIL srst_stays_idle: got %b expected 0", busy); end
        if (cs_n !== 2'b11)    begin tests_failed++; $display("FAIL srst_cs_idle: got %b expected 11", cs_n); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        srst = 1'b1; tx_data = '0; tx_wr_en = 1'b0; rx_rd_en = 1'b0;
        cpol = 1'b0; cpha = 1'b0; clk_div = '0; cs_sel = '0;
        loop = 1'b1; slave_miso = 1'b0; slave_tx = '0; cap = '0; cap_n = 0;
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_full_overflow();
        test_config_latch();
        test_srst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
